mdu: RTL and testbench

Parametrised, iterative multiply/divide unit: the sequential companion to the single-cycle ALU in the execute stage, implementing the RV32M operations at any operand width. Operands are accepted through a valid/ready handshake. The unit computes over a fixed number of cycles, then holds the result until the consumer takes it. The execute stage stalls on it; the unit never raises exceptions.

---
 rtl/mdu_pkg.sv | 30 +++
 rtl/mdu_div_step.sv | 29 ++
 rtl/mdu.sv | 224 ++++++++++++++++++++++
 tb/tb_mdu.sv | 298 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mdu_pkg.sv
// mdu_pkg: shared types for the iterative multiply/divide unit.
//   mdu_op_t    - RV32M funct3 operation encodings (MDU_MUL .. MDU_REMU)
//   mdu_state_t - control FSM states (IDLE, BUSY, DONE)
//   mdu_cnt_w() - iteration counter width for a given operand width
// Optional divider datapath is selected in mdu.sv by the MDU_DIV_EN macro.
package mdu_pkg;

    typedef enum logic [2:0] {
        MDU_MUL    = 3'd0,
        MDU_MULH   = 3'd1,
        MDU_MULHSU = 3'd2,
        MDU_MULHU  = 3'd3,
        MDU_DIV    = 3'd4,
        MDU_DIVU   = 3'd5,
        MDU_REM    = 3'd6,
        MDU_REMU   = 3'd7
    } mdu_op_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } mdu_state_t;

    // Counter runs BITSIZE-1 down to 0, so $clog2(BITSIZE) bits suffice.
    function automatic int mdu_cnt_w(input int bitsize);
        return $clog2(bitsize);
    endfunction

endpackage

// File: rtl/mdu_div_step.sv
// mdu_div_step: one combinational restoring-division iteration on magnitudes.
//   rem_i [BITSIZE:0]   partial remainder in
//   quo_i [BITSIZE-1:0] quotient/dividend shift register in (MSB is next dividend bit)
//   div_i [BITSIZE-1:0] divisor magnitude
//   rem_o, quo_o        updated remainder and quotient
// Only instantiated when MDU_DIV_EN is defined.
module mdu_div_step #(
    parameter int BITSIZE = 32
) (
    input  logic [BITSIZE:0]   rem_i,
    input  logic [BITSIZE-1:0] quo_i,
    input  logic [BITSIZE-1:0] div_i,
    output logic [BITSIZE:0]   rem_o,
    output logic [BITSIZE-1:0] quo_o
);

    logic [BITSIZE+1:0] shifted_s;
    logic [BITSIZE+1:0] diff_s;
    logic               ge_s;

    // Trial subtraction one bit wider than the shifted remainder so that the
    // MSB is a true borrow (shifted value is always below 2^(BITSIZE+1)).
    assign shifted_s = {rem_i, quo_i[BITSIZE-1]};
    assign diff_s    = shifted_s - {2'b00, div_i};
    assign ge_s      = ~diff_s[BITSIZE+1];
    assign rem_o     = ge_s ? diff_s[BITSIZE:0] : shifted_s[BITSIZE:0];
    assign quo_o     = {quo_i[BITSIZE-2:0], ge_s};

endmodule

// File: rtl/mdu.sv
// mdu: iterative RV32M multiply/divide unit with valid/ready handshakes.
//   clk, rst_i (sync, active-high), flush_i (abort, drops result)
//   valid_i/ready_o  operand handshake; operation_i = funct3, A_i = rs1, B_i = rs2
//   valid_o/ready_i  result handshake; R_o result; div_zero_o flags divide by zero
// Multiply: radix-2 shift-add on magnitudes, BITSIZE iterations.
// Divide: restoring on magnitudes, BITSIZE iterations, with single-cycle
// fast paths for divide-by-zero and signed overflow.
// Macro MDU_DIV_EN: when undefined there is no divider; ops 4-7 complete in
// one cycle with R_o=0 and div_zero_o=0.
module mdu
    import mdu_pkg::*;
#(
    parameter int BITSIZE = 32
) (
    input  logic               clk,
    input  logic               rst_i,
    input  logic               flush_i,
    input  logic               valid_i,
    output logic               ready_o,
    input  logic [2:0]         operation_i,
    input  logic [BITSIZE-1:0] A_i,
    input  logic [BITSIZE-1:0] B_i,
    output logic               valid_o,
    input  logic               ready_i,
    output logic [BITSIZE-1:0] R_o,
    output logic               div_zero_o
);

    localparam int CNT_W = mdu_cnt_w(BITSIZE);
    localparam logic [BITSIZE-1:0] ZERO_W = {BITSIZE{1'b0}};

    mdu_state_t             state_q, state_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    mdu_op_t                op_q, op_d;
    logic                   neg_q, neg_d;
    logic [BITSIZE-1:0]     mag_q, mag_d;      // multiplicand or divisor magnitude
    logic [2*BITSIZE-1:0]   acc_q, acc_d;      // product, or quotient in low half
    logic                   ready_q, ready_d;
    logic                   valid_q, valid_d;
    logic [BITSIZE-1:0]     r_q, r_d;
    logic                   dz_q, dz_d;

    mdu_op_t                op_in_s;
    logic                   a_signed_s, b_signed_s, a_neg_s, b_neg_s;
    logic [BITSIZE-1:0]     a_mag_s, b_mag_s;
    logic [BITSIZE:0]       sum_s;
    logic [2*BITSIZE-1:0]   mul_next_s, prod_s;
    logic [BITSIZE-1:0]     mul_res_s, fin_res_s;

    // Operand signedness and magnitudes for the incoming operation.
    assign op_in_s    = mdu_op_t'(operation_i);
    assign a_signed_s = (op_in_s != MDU_MULHU) && (op_in_s != MDU_DIVU) && (op_in_s != MDU_REMU);
    assign b_signed_s = (op_in_s == MDU_MUL) || (op_in_s == MDU_MULH) ||
                        (op_in_s == MDU_DIV) || (op_in_s == MDU_REM);
    assign a_neg_s    = a_signed_s & A_i[BITSIZE-1];
    assign b_neg_s    = b_signed_s & B_i[BITSIZE-1];
    assign a_mag_s    = a_neg_s ? (ZERO_W - A_i) : A_i;
    assign b_mag_s    = b_neg_s ? (ZERO_W - B_i) : B_i;

    // Shift-add step: the multiplier sits in the low half and is consumed LSB first.
    assign sum_s      = {1'b0, acc_q[2*BITSIZE-1:BITSIZE]} +
                        (acc_q[0] ? {1'b0, mag_q} : {(BITSIZE+1){1'b0}});
    assign mul_next_s = {sum_s, acc_q[BITSIZE-1:1]};
    assign prod_s     = neg_q ? ({(2*BITSIZE){1'b0}} - mul_next_s) : mul_next_s;
    assign mul_res_s  = (op_q == MDU_MUL) ? prod_s[BITSIZE-1:0] : prod_s[2*BITSIZE-1:BITSIZE];

`ifdef MDU_DIV_EN
    logic [BITSIZE:0]   rem_q, rem_d;
    logic [BITSIZE:0]   rem_step_s;
    logic [BITSIZE-1:0] quo_step_s, quo_fix_s, rem_fix_s, div_res_s;
    logic               min_s, is_sdiv_s;

    mdu_div_step #(
        .BITSIZE (BITSIZE)
    ) u_div_step (
        .rem_i (rem_q),
        .quo_i (acc_q[BITSIZE-1:0]),
        .div_i (mag_q),
        .rem_o (rem_step_s),
        .quo_o (quo_step_s)
    );

    assign quo_fix_s = neg_q ? (ZERO_W - quo_step_s) : quo_step_s;
    assign rem_fix_s = neg_q ? (ZERO_W - rem_step_s[BITSIZE-1:0]) : rem_step_s[BITSIZE-1:0];
    assign div_res_s = ((op_q == MDU_DIV) || (op_q == MDU_DIVU)) ? quo_fix_s : rem_fix_s;
    assign fin_res_s = op_q[2] ? div_res_s : mul_res_s;
    assign min_s     = (A_i == {1'b1, {(BITSIZE-1){1'b0}}});
    assign is_sdiv_s = (op_in_s == MDU_DIV) || (op_in_s == MDU_REM);
`else
    assign fin_res_s = mul_res_s;
`endif

    // Next-state, datapath and registered-output computation.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        op_d    = op_q;
        neg_d   = neg_q;
        mag_d   = mag_q;
        acc_d   = acc_q;
        r_d     = r_q;
        dz_d    = dz_q;
`ifdef MDU_DIV_EN
        rem_d   = rem_q;
`endif
        case (state_q)
            IDLE: begin
                if (valid_i) begin
                    op_d  = op_in_s;
                    cnt_d = CNT_W'(BITSIZE - 1);
                    dz_d  = 1'b0;
                    if (!op_in_s[2]) begin
                        neg_d   = a_neg_s ^ b_neg_s;
                        mag_d   = a_mag_s;
                        acc_d   = {ZERO_W, b_mag_s};
                        state_d = BUSY;
                    end else begin
`ifdef MDU_DIV_EN
                        // Remainder follows the dividend sign, quotient the XOR.
                        neg_d = ((op_in_s == MDU_REM) || (op_in_s == MDU_REMU)) ?
                                a_neg_s : (a_neg_s ^ b_neg_s);
                        mag_d = b_mag_s;
                        acc_d = {ZERO_W, a_mag_s};
                        rem_d = {(BITSIZE+1){1'b0}};
                        if (B_i == ZERO_W) begin
                            state_d = DONE;
                            dz_d    = 1'b1;
                            r_d     = ((op_in_s == MDU_DIV) || (op_in_s == MDU_DIVU)) ?
                                      {BITSIZE{1'b1}} : A_i;
                        end else if (is_sdiv_s && min_s && (B_i == {BITSIZE{1'b1}})) begin
                            state_d = DONE;
                            r_d     = (op_in_s == MDU_DIV) ? A_i : ZERO_W;
                        end else begin
                            state_d = BUSY;
                        end
`else
                        state_d = DONE;
                        r_d     = ZERO_W;
`endif
                    end
                end else begin
                    state_d = IDLE;
                end
            end
            BUSY: begin
                cnt_d = cnt_q - CNT_W'(1);
`ifdef MDU_DIV_EN
                if (op_q[2]) begin
                    acc_d = {ZERO_W, quo_step_s};
                    rem_d = rem_step_s;
                end else begin
                    acc_d = mul_next_s;
                end
`else
                acc_d = mul_next_s;
`endif
                if (cnt_q == {CNT_W{1'b0}}) begin
                    state_d = DONE;
                    r_d     = fin_res_s;
                end else begin
                    state_d = BUSY;
                end
            end
            DONE: begin
                if (ready_i) begin
                    state_d = IDLE;
                end else begin
                    state_d = DONE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (flush_i) begin
            state_d = IDLE;
        end else begin
            state_d = state_d;
        end

        ready_d = (state_d == IDLE);
        valid_d = (state_d == DONE);
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst_i) begin
            state_q <= IDLE;
            cnt_q   <= {CNT_W{1'b0}};
            op_q    <= MDU_MUL;
            neg_q   <= 1'b0;
            mag_q   <= ZERO_W;
            acc_q   <= {(2*BITSIZE){1'b0}};
            ready_q <= 1'b1;
            valid_q <= 1'b0;
            r_q     <= ZERO_W;
            dz_q    <= 1'b0;
`ifdef MDU_DIV_EN
            rem_q   <= {(BITSIZE+1){1'b0}};
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            op_q    <= op_d;
            neg_q   <= neg_d;
            mag_q   <= mag_d;
            acc_q   <= acc_d;
            ready_q <= ready_d;
            valid_q <= valid_d;
            r_q     <= r_d;
            dz_q    <= dz_d;
`ifdef MDU_DIV_EN
            rem_q   <= rem_d;
`endif
        end
    end

    assign ready_o    = ready_q;
    assign valid_o    = valid_q;
    assign R_o        = r_q;
    assign div_zero_o = dz_q;

endmodule

// File: tb/tb_mdu.sv
// tb_mdu: self-checking bench for mdu (BITSIZE=32). Table-driven vectors plus
// model-checked random operations flow through an expected-result queue;
// hand-written sequences cover stall, ignored valid, flush and mid-op reset.
module tb_mdu;

    localparam int W = 32;

    logic          clk = 1'b0;
    logic          rst_i, flush_i, valid_i, ready_i;
    logic [2:0]    operation_i;
    logic [W-1:0]  A_i, B_i;
    logic          ready_o, valid_o, div_zero_o;
    logic [W-1:0]  R_o;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [2:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] r;
        logic        dz;
        int          lat;
    } vec_t;

    typedef struct {
        logic [31:0] r;
        logic        dz;
        int          lat;
    } exp_t;

    exp_t sb_q[$];
    vec_t vecs[16];

    mdu #(.BITSIZE(W)) dut (
        .clk         (clk),
        .rst_i       (rst_i),
        .flush_i     (flush_i),
        .valid_i     (valid_i),
        .ready_o     (ready_o),
        .operation_i (operation_i),
        .A_i         (A_i),
        .B_i         (B_i),
        .valid_o     (valid_o),
        .ready_i     (ready_i),
        .R_o         (R_o),
        .div_zero_o  (div_zero_o)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    task automatic chk1(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%b expected=%b", name, act, exp);
        end
    endtask

    // Reference RV32M behaviour using 64-bit arithmetic.
    function automatic exp_t model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        exp_t e;
        longint sa, sb;
        longint unsigned ua, ub, p;
        e.dz  = 1'b0;
        e.lat = W + 1;
        e.r   = 32'd0;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = {32'd0, a};
        ub = {32'd0, b};
        case (op)
            3'd0: begin p = ua * ub; e.r = p[31:0]; end
            3'd1: begin p = sa * sb; e.r = p[63:32]; end
            3'd2: begin p = sa * longint'(ub); e.r = p[63:32]; end
            3'd3: begin p = ua * ub; e.r = p[63:32]; end
            default: begin
`ifdef MDU_DIV_EN
                if (b == 32'd0) begin
                    e.r   = (op == 3'd4 || op == 3'd5) ? 32'hFFFF_FFFF : a;
                    e.dz  = 1'b1;
                    e.lat = 1;
                end else if ((op == 3'd4 || op == 3'd6) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
                    e.r   = (op == 3'd4) ? a : 32'd0;
                    e.lat = 1;
                end else begin
                    case (op)
                        3'd4:    e.r = 32'(sa / sb);
                        3'd5:    e.r = 32'(ua / ub);
                        3'd6:    e.r = 32'(sa % sb);
                        default: e.r = 32'(ua % ub);
                    endcase
                end
`else
                e.r   = 32'd0;
                e.lat = 1;
`endif
            end
        endcase
        return e;
    endfunction

    // One full transaction: drive, push expectation, wait for result, pop and compare.
    task automatic run_op(input string name, input logic [2:0] op, input logic [31:0] a,
                          input logic [31:0] b, input exp_t e);
        exp_t x;
        int   lat;
        logic busy_ok;
        lat = 0;
        while (!ready_o && lat < 100) begin
            @(negedge clk);
            lat++;
        end
        chk1({name, "_ready_in"}, ready_o, 1'b1);
        operation_i = op;
        A_i = a;
        B_i = b;
        valid_i = 1'b1;
        sb_q.push_back(e);
        @(negedge clk);
        valid_i = 1'b0;
        A_i = $urandom;
        B_i = $urandom;
        operation_i = 3'($urandom_range(0, 7));
        lat = 1;
        busy_ok = 1'b1;
        while (!valid_o && lat < 200) begin
            if (ready_o) busy_ok = 1'b0;
            @(negedge clk);
            lat++;
        end
        x = sb_q.pop_front();
        chk({name, "_latency"}, lat, x.lat);
        chk({name, "_R"}, R_o, x.r);
        chk1({name, "_divzero"}, div_zero_o, x.dz);
        chk1({name, "_ready_low_busy"}, busy_ok, 1'b1);
        ready_i = 1'b1;
        @(negedge clk);
        ready_i = 1'b0;
        chk1({name, "_valid_drop"}, valid_o, 1'b0);
    endtask

    initial begin
        exp_t e;
        logic [2:0]  rop;
        logic [31:0] ra, rb;
        logic        seen;

        vecs = '{
            '{3'd0, 32'd7,          32'hFFFF_FFFD, 32'hFFFF_FFEB, 1'b0, 33},
            '{3'd3, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'hFFFF_FFFE, 1'b0, 33},
            '{3'd2, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 33},
            '{3'd1, 32'h8000_0000,  32'h8000_0000, 32'h4000_0000, 1'b0, 33},
            '{3'd0, 32'h8000_0000,  32'hFFFF_FFFF, 32'h8000_0000, 1'b0, 33},
            '{3'd4, 32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFD, 1'b0, 33},
            '{3'd6, 32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFF, 1'b0, 33},
            '{3'd5, 32'd100,        32'd7,         32'd14,        1'b0, 33},
            '{3'd7, 32'd100,        32'd7,         32'd2,         1'b0, 33},
            '{3'd4, 32'd5,          32'd0,         32'hFFFF_FFFF, 1'b1, 1},
            '{3'd6, 32'd5,          32'd0,         32'd5,         1'b1, 1},
            '{3'd5, 32'd5,          32'd0,         32'hFFFF_FFFF, 1'b1, 1},
            '{3'd4, 32'h8000_0000,  32'hFFFF_FFFF, 32'h8000_0000, 1'b0, 1},
            '{3'd6, 32'h8000_0000,  32'hFFFF_FFFF, 32'd0,         1'b0, 1},
            '{3'd5, 32'h8000_0000,  32'hFFFF_FFFF, 32'd0,         1'b0, 33},
            '{3'd6, 32'd7,          32'hFFFF_FFFE, 32'd1,         1'b0, 33}
        };

        rst_i = 1'b1;
        flush_i = 1'b0;
        valid_i = 1'b0;
        ready_i = 1'b0;
        operation_i = 3'd0;
        A_i = 32'd0;
        B_i = 32'd0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_i = 1'b0;

        chk1("reset_ready", ready_o, 1'b1);
        chk1("reset_valid", valid_o, 1'b0);
        chk("reset_R", R_o, 32'd0);
        chk1("reset_divzero", div_zero_o, 1'b0);

        for (int i = 0; i < 16; i++) begin
            e.r = vecs[i].r;
            e.dz = vecs[i].dz;
            e.lat = vecs[i].lat;
`ifndef MDU_DIV_EN
            if (vecs[i].op[2]) begin
                e.r = 32'd0;
                e.dz = 1'b0;
                e.lat = 1;
            end
`endif
            run_op($sformatf("vec%0d", i), vecs[i].op, vecs[i].a, vecs[i].b, e);
        end

        for (int i = 0; i < 12; i++) begin
            rop = 3'($urandom_range(0, 7));
            ra = $urandom;
            rb = (i % 3 == 0) ? 32'($urandom_range(0, 9)) : $urandom;
            e = model(rop, ra, rb);
            run_op($sformatf("rand%0d_op%0d", i, rop), rop, ra, rb, e);
        end

        // Stall in DONE and a valid_i pulse during BUSY.
        operation_i = 3'd0; A_i = 32'd3; B_i = 32'd5; valid_i = 1'b1;
        @(negedge clk);
        valid_i = 1'b0;
        repeat (3) @(negedge clk);
        operation_i = 3'd0; A_i = 32'd9; B_i = 32'd9; valid_i = 1'b1;
        @(negedge clk);
        valid_i = 1'b0;
        for (int n = 0; n < 100 && !valid_o; n++) @(negedge clk);
        chk1("stall_valid", valid_o, 1'b1);
        chk("stall_R", R_o, 32'd15);
        for (int n = 0; n < 10; n++) begin
            @(negedge clk);
            chk("stall_R_hold", R_o, 32'd15);
            chk1("stall_valid_hold", valid_o, 1'b1);
        end
        ready_i = 1'b1;
        @(negedge clk);
        ready_i = 1'b0;
        seen = 1'b0;
        for (int n = 0; n < 40; n++) begin
            if (valid_o) seen = 1'b1;
            @(negedge clk);
        end
        chk1("busy_valid_ignored", seen, 1'b0);
        chk1("busy_valid_ignored_ready", ready_o, 1'b1);

        // Flush at BUSY cycle 5.
        operation_i = 3'd0; A_i = 32'd7; B_i = 32'hFFFF_FFFD; valid_i = 1'b1;
        @(negedge clk);
        valid_i = 1'b0;
        repeat (4) @(negedge clk);
        chk1("flush_busy_before", ready_o, 1'b0);
        flush_i = 1'b1;
        @(negedge clk);
        flush_i = 1'b0;
        chk1("flush_ready", ready_o, 1'b1);
        chk1("flush_valid", valid_o, 1'b0);
        seen = 1'b0;
        for (int n = 0; n < 40; n++) begin
            if (valid_o) seen = 1'b1;
            @(negedge clk);
        end
        chk1("flush_no_result", seen, 1'b0);

        // Flush together with valid_i in IDLE: not accepted.
        operation_i = 3'd0; A_i = 32'd2; B_i = 32'd2; valid_i = 1'b1; flush_i = 1'b1;
        @(negedge clk);
        valid_i = 1'b0; flush_i = 1'b0;
        chk1("flush_with_valid_ready", ready_o, 1'b1);

        // Reset in the middle of BUSY.
        operation_i = 3'd0; A_i = 32'd7; B_i = 32'hFFFF_FFFD; valid_i = 1'b1;
        @(negedge clk);
        valid_i = 1'b0;
        repeat (10) @(negedge clk);
        rst_i = 1'b1;
        @(negedge clk);
        rst_i = 1'b0;
        chk1("midrst_ready", ready_o, 1'b1);
        chk1("midrst_valid", valid_o, 1'b0);
        chk("midrst_R", R_o, 32'd0);
        chk1("midrst_divzero", div_zero_o, 1'b0);
        seen = 1'b0;
        for (int n = 0; n < 40; n++) begin
            if (valid_o) seen = 1'b1;
            @(negedge clk);
        end
        chk1("midrst_no_result", seen, 1'b0);

        e = model(3'd0, 32'd7, 32'hFFFF_FFFD);
        run_op("after_reset_mul", 3'd0, 32'd7, 32'hFFFF_FFFD, e);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
